// File: rtl/mips_cpu_pkg.sv
// Shared constants for the multi-cycle MIPS-I core: opcode/funct encodings,
// FSM states, ALU operations and write-back selectors.
package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
    localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h00000000;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    typedef enum logic [2:0] {
        WB_ALU, WB_MEM, WB_LINK, WB_HI, WB_LO
    } wb_sel_t;

    typedef enum logic [2:0] {
        MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
    } md_op_t;

endpackage

// File: rtl/mips_cpu_alu.sv
// Combinational ALU: add/sub, logic ops, signed/unsigned compare, shifter, LUI.
module mips_cpu_alu
    import mips_cpu_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] y
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    assign a_s = a;
    assign b_s = b;

    // One result per operation; shifts act on b, comparisons yield 0/1
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = {31'b0, (a_s < b_s)};
            ALU_SLTU: y = {31'b0, (a < b)};
            ALU_SLL:  y = b << shamt;
            ALU_SRL:  y = b >> shamt;
            ALU_SRA:  y = b_s >>> shamt;
            ALU_LUI:  y = {b[15:0], 16'b0};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/mips_cpu_bus.sv
// Multi-cycle MIPS-I subset core on a single shared Avalon-style bus.
// FETCH -> DECODE -> EXEC -> (MEM) -> WB, one delay slot on branches/jumps,
// halts once the next fetch address equals HALT_ADDR.
// Optional HI/LO multiply/divide unit enabled by defining MIPS_MULTDIV_EN.
module mips_cpu_bus
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    state_t      state, state_nx;
    logic        started;
    logic [31:0] pc, npc;
    logic [31:0] regs [0:31];
    logic [31:0] ir, a_reg, b_reg, alu_r, tgt;
    logic        take;

    logic [5:0]  opc, funct;
    logic [4:0]  rt, rd, sa;
    logic [15:0] imm;
    logic [31:0] imm_ext, br_tgt, j_tgt, alu_b, alu_y, wb_data;
    logic [4:0]  alu_sh, wb_dst;
    alu_op_t     alu_op;
    wb_sel_t     wb_sel;
    logic        use_imm, imm_zext, shift_var, wb_en, is_load, is_store, take_c;
    logic [31:0] tgt_c;
`ifdef MIPS_MULTDIV_EN
    md_op_t      md_op;
    logic [31:0] hi, lo;
`endif

    assign opc   = ir[31:26];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign sa    = ir[10:6];
    assign funct = ir[5:0];
    assign imm   = ir[15:0];

    assign imm_ext = imm_zext ? {16'b0, imm} : {{16{imm[15]}}, imm};
    assign br_tgt  = npc + {{14{imm[15]}}, imm, 2'b00};
    assign j_tgt   = {npc[31:28], ir[25:0], 2'b00};
    assign alu_b   = use_imm ? imm_ext : b_reg;
    assign alu_sh  = shift_var ? a_reg[4:0] : sa;

    assign active      = started && (state != S_HALTED);
    assign register_v0 = regs[2];

    mips_cpu_alu u_alu (
        .op    (alu_op),
        .a     (a_reg),
        .b     (alu_b),
        .shamt (alu_sh),
        .y     (alu_y)
    );

    // Instruction decode plus branch/jump resolution from the latched operands
    always_comb begin
        alu_op    = ALU_ADD;
        use_imm   = 1'b0;
        imm_zext  = 1'b0;
        shift_var = 1'b0;
        wb_en     = 1'b0;
        wb_dst    = rd;
        wb_sel    = WB_ALU;
        is_load   = 1'b0;
        is_store  = 1'b0;
        take_c    = 1'b0;
        tgt_c     = br_tgt;
`ifdef MIPS_MULTDIV_EN
        md_op     = MD_NONE;
`endif
        // ADDIU..LUI share the immediate-operand, rt-destination shape
        if (opc[5:3] == 3'b001 && opc[2:0] != 3'b000) begin
            use_imm  = 1'b1;
            wb_en    = 1'b1;
            wb_dst   = rt;
            imm_zext = opc[2] && (opc[1:0] != 2'b11);
        end
        case (opc)
            OP_SPECIAL: begin
                wb_en = 1'b1;
                case (funct)
                    F_SLL:  alu_op = ALU_SLL;
                    F_SRL:  alu_op = ALU_SRL;
                    F_SRA:  alu_op = ALU_SRA;
                    F_SLLV: begin alu_op = ALU_SLL; shift_var = 1'b1; end
                    F_SRLV: begin alu_op = ALU_SRL; shift_var = 1'b1; end
                    F_SRAV: begin alu_op = ALU_SRA; shift_var = 1'b1; end
                    F_ADDU: alu_op = ALU_ADD;
                    F_SUBU: alu_op = ALU_SUB;
                    F_AND:  alu_op = ALU_AND;
                    F_OR:   alu_op = ALU_OR;
                    F_XOR:  alu_op = ALU_XOR;
                    F_SLT:  alu_op = ALU_SLT;
                    F_SLTU: alu_op = ALU_SLTU;
                    F_JR:   begin wb_en = 1'b0; take_c = 1'b1; tgt_c = a_reg; end
                    F_JALR: begin wb_sel = WB_LINK; take_c = 1'b1; tgt_c = a_reg; end
`ifdef MIPS_MULTDIV_EN
                    F_MFHI:  wb_sel = WB_HI;
                    F_MFLO:  wb_sel = WB_LO;
                    F_MTHI:  begin wb_en = 1'b0; md_op = MD_MTHI; end
                    F_MTLO:  begin wb_en = 1'b0; md_op = MD_MTLO; end
                    F_MULT:  begin wb_en = 1'b0; md_op = MD_MULT; end
                    F_MULTU: begin wb_en = 1'b0; md_op = MD_MULTU; end
                    F_DIV:   begin wb_en = 1'b0; md_op = MD_DIV; end
                    F_DIVU:  begin wb_en = 1'b0; md_op = MD_DIVU; end
`endif
                    default: wb_en = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                if (rt == 5'd0)      take_c = a_reg[31];
                else if (rt == 5'd1) take_c = !a_reg[31];
            end
            OP_J:    begin take_c = 1'b1; tgt_c = j_tgt; end
            OP_JAL:  begin
                take_c = 1'b1;
                tgt_c  = j_tgt;
                wb_en  = 1'b1;
                wb_dst = 5'd31;
                wb_sel = WB_LINK;
            end
            OP_BEQ:   take_c = (a_reg == b_reg);
            OP_BNE:   take_c = (a_reg != b_reg);
            OP_BLEZ:  take_c = a_reg[31] || (a_reg == 32'd0);
            OP_BGTZ:  take_c = !a_reg[31] && (a_reg != 32'd0);
            OP_SLTI:  alu_op = ALU_SLT;
            OP_SLTIU: alu_op = ALU_SLTU;
            OP_ANDI:  alu_op = ALU_AND;
            OP_ORI:   alu_op = ALU_OR;
            OP_XORI:  alu_op = ALU_XOR;
            OP_LUI:   alu_op = ALU_LUI;
            OP_LW: begin
                use_imm = 1'b1;
                is_load = 1'b1;
                wb_en   = 1'b1;
                wb_dst  = rt;
                wb_sel  = WB_MEM;
            end
            OP_SW: begin
                use_imm  = 1'b1;
                is_store = 1'b1;
            end
            default: ;
        endcase
    end

    // Write-back source select; load data is taken straight off the bus
    always_comb begin
        case (wb_sel)
            WB_MEM:  wb_data = readdata;
            WB_LINK: wb_data = pc + 32'd8;
`ifdef MIPS_MULTDIV_EN
            WB_HI:   wb_data = hi;
            WB_LO:   wb_data = lo;
`endif
            default: wb_data = alu_r;
        endcase
    end

    // Next state and bus strobes; requests hold while waitrequest is high
    always_comb begin
        state_nx  = state;
        read      = 1'b0;
        write     = 1'b0;
        address   = '0;
        writedata = '0;
        case (state)
            S_FETCH: begin
                if (started) begin
                    read    = 1'b1;
                    address = {pc[31:2], 2'b00};
                    if (!waitrequest) state_nx = S_DECODE;
                end
            end
            S_DECODE: state_nx = S_EXEC;
            S_EXEC:   state_nx = (is_load || is_store) ? S_MEM : S_WB;
            S_MEM: begin
                address   = {alu_r[31:2], 2'b00};
                read      = is_load;
                write     = is_store;
                writedata = is_store ? b_reg : 32'd0;
                if (!waitrequest) state_nx = S_WB;
            end
            S_WB:     state_nx = (npc == HALT_ADDR) ? S_HALTED : S_FETCH;
            default:  state_nx = S_HALTED;
        endcase
        byteenable = (read || write) ? 4'b1111 : 4'b0000;
    end

    // Control state, program counters and register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            started <= 1'b0;
            pc      <= RESET_VECTOR;
            npc     <= RESET_VECTOR + 32'd4;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            state   <= state_nx;
            started <= 1'b1;
            if (state == S_WB) begin
                pc  <= npc;
                npc <= take ? tgt : npc + 32'd4;
                if (wb_en && wb_dst != 5'd0) regs[wb_dst] <= wb_data;
            end
        end
    end

    // Datapath latches: IR and operands at DECODE, ALU result and branch outcome at EXEC
    always_ff @(posedge clk) begin
        if (state == S_DECODE) begin
            ir    <= readdata;
            a_reg <= regs[readdata[25:21]];
            b_reg <= regs[readdata[20:16]];
        end
        if (state == S_EXEC) begin
            alu_r <= alu_y;
            take  <= take_c;
            tgt   <= tgt_c;
        end
    end

`ifdef MIPS_MULTDIV_EN
    logic signed [31:0] a_s, b_s;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign a_s    = a_reg;
    assign b_s    = b_reg;
    assign prod_s = a_s * b_s;
    assign prod_u = {32'b0, a_reg} * {32'b0, b_reg};

    // HI/LO update at write-back; divide by zero leaves both untouched
    always_ff @(posedge clk) begin
        if (state == S_WB) begin
            case (md_op)
                MD_MULT:  {hi, lo} <= prod_s;
                MD_MULTU: {hi, lo} <= prod_u;
                MD_DIV:   if (b_reg != 32'd0) begin lo <= a_s / b_s; hi <= a_s % b_s; end
                MD_DIVU:  if (b_reg != 32'd0) begin lo <= a_reg / b_reg; hi <= a_reg % b_reg; end
                MD_MTHI:  hi <= a_reg;
                MD_MTLO:  lo <= a_reg;
                default:  ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Program-level bench for mips_cpu_bus: a table of small programs with
// hand-computed final $v0 values, a bus responder with optional stalls,
// and a mid-transaction reset sequence.
module tb_mips_cpu_bus;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        active, write, read;
    logic        waitrequest = 1'b0;
    logic [31:0] register_v0, address, writedata;
    logic [31:0] readdata = 32'd0;
    logic [3:0]  byteenable;

    int n_checks = 0;
    int n_pass   = 0;

    mips_cpu_bus #(.RESET_VECTOR(RV), .HALT_ADDR(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][31:0] prog;
        logic [31:0]      exp_v0;
        logic             stall;
    } vec_t;

    vec_t vecs [10];

    logic [31:0] mem [0:63];
    int          wait_left = 0;
    logic        stall_fetch_arm = 1'b0;
    logic        stall_sw_arm = 1'b0;
    logic [65:0] snap;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_data = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] e, input logic s,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input logic [31:0] w4, input logic [31:0] w5,
                                input logic [31:0] w6, input logic [31:0] w7);
        vec_t v;
        v.prog   = {w7, w6, w5, w4, w3, w2, w1, w0};
        v.exp_v0 = e;
        v.stall  = s;
        return v;
    endfunction

    // Bus responder: reads return data the cycle after acceptance; optional 5-cycle stalls
    always @(negedge clk) begin
        if (!reset) begin
            waitrequest = 1'b0;
            wait_left   = 0;
            rd_pend     = 1'b0;
        end else begin
            if (rd_pend) begin
                readdata = rd_data;
                rd_pend  = 1'b0;
            end
            check("rw_exclusive", {63'd0, read & write}, 64'd0);
            if (wait_left > 0) begin
                check("stall_hold", {read, write, address, writedata}, snap);
                wait_left   = wait_left - 1;
                waitrequest = 1'b1;
            end else if ((read && stall_fetch_arm && address == RV) || (write && stall_sw_arm)) begin
                snap        = {read, write, address, writedata};
                if (read) stall_fetch_arm = 1'b0;
                else      stall_sw_arm = 1'b0;
                wait_left   = 4;
                waitrequest = 1'b1;
            end else begin
                waitrequest = 1'b0;
                if (read) begin
                    rd_data = mem[address[7:2]];
                    rd_pend = 1'b1;
                end
                if (write) mem[address[7:2]] = writedata;
            end
        end
    end

    task automatic load(input int k);
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        for (int i = 0; i < 8; i++) mem[i] = vecs[k].prog[i];
        mem[11] = 32'h00000001;
        stall_fetch_arm = vecs[k].stall;
        stall_sw_arm    = vecs[k].stall;
    endtask

    task automatic run_vec(input int k);
        int cyc;
        reset = 1'b0;
        load(k);
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("v%0d_rst_bus", k), {25'd0, active, read, write, byteenable, address}, 64'd0);
        check($sformatf("v%0d_rst_v0", k), {32'd0, register_v0}, 64'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("v%0d_boot", k), {30'd0, active, read, address}, {30'd0, 1'b1, 1'b1, RV});
        cyc = 0;
        while (active && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("v%0d_halted", k), {63'd0, active}, 64'd0);
        check($sformatf("v%0d_v0", k), {32'd0, register_v0}, {32'd0, vecs[k].exp_v0});
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("v%0d_idle", k), {61'd0, active, read, write}, 64'd0);
    endtask

    initial begin
        int cyc;
        vecs[0] = mk(32'hBFC0000C, 1'b0, 32'h3C08BFC0, 32'h0FF00006, 32'h8D090000, 32'h00000008,
                     32'h00000000, 32'h00000000, 32'h00000008, 32'h27E20000);
        vecs[1] = mk(32'h00000001, 1'b0, 32'h3C08BFC0, 32'h8D02002C, 32'h00000008, 32'h00000000,
                     32'h0, 32'h0, 32'h0, 32'h0);
        vecs[2] = mk(32'h00000055, 1'b1, 32'h3C08BFC0, 32'h24020055, 32'hAD020040, 32'h24020000,
                     32'h8D020040, 32'h00000008, 32'h0, 32'h0);
        vecs[3] = mk(32'h00000006, 1'b0, 32'h10000002, 32'h24020005, 32'h24420064, 32'h24420001,
                     32'h00000008, 32'h0, 32'h0, 32'h0);
        vecs[4] = mk(32'h00000000, 1'b0, 32'h24000007, 32'h00001021, 32'h00000008, 32'h0,
                     32'h0, 32'h0, 32'h0, 32'h0);
        vecs[5] = mk(32'hFFFFFFFE, 1'b0, 32'h2402FFFD, 32'h00021043, 32'h00000008, 32'h0,
                     32'h0, 32'h0, 32'h0, 32'h0);
        vecs[6] = mk(32'h00000001, 1'b0, 32'h34088000, 32'h24098000, 32'h0109102B, 32'h00000008,
                     32'h0, 32'h0, 32'h0, 32'h0);
        vecs[7] = mk(32'h0000F0FF, 1'b0, 32'h24090004, 32'h240200F0, 32'h01221004, 32'h3842FFFF,
                     32'h00000008, 32'h0, 32'h0, 32'h0);
        vecs[8] = mk(32'h00000014, 1'b0, 32'h24020003, 32'h04400002, 32'h24420001, 32'h24420010,
                     32'h00000008, 32'h0, 32'h0, 32'h0);
        vecs[9] = mk(32'h00000001, 1'b0, 32'h2409FFFF, 32'h0120102A, 32'h00000008, 32'h0,
                     32'h0, 32'h0, 32'h0, 32'h0);

        for (int k = 0; k < 10; k++) run_vec(k);

        // Reset asserted while a store is on the bus: strobes must drop at once
        reset = 1'b0;
        load(2);
        stall_fetch_arm = 1'b0;
        stall_sw_arm    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        cyc = 0;
        while (!write && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("abort_store_seen", {63'd0, write}, 64'd1);
        check("abort_store_addr", {32'd0, address}, {32'd0, 32'hBFC00040});
        #2 reset = 1'b0;
        #1;
        check("abort_idle", {25'd0, active, read, write, byteenable, address}, 64'd0);
        check("abort_v0_cleared", {32'd0, register_v0}, 64'd0);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus.md
Name:
mips_cpu_bus

Overview:
Multi-cycle MIPS-I subset CPU with a single Avalon-style memory bus shared by instruction fetch and data access. It boots from 0xBFC00000 and executes until a jump to address 0, then drops `active` and idles. Register $2 (v0) is exported for checking. It is the top-level core; memory is external.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value after reset.
HALT_ADDR, 32'h00000000, PC value that stops execution.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
active  output  1  high while executing; low after halt and during reset.
register_v0  output  32  live copy of GPR $2.
address  output  32  byte address, always word aligned (bits[1:0]=0).
write  output  1  write strobe.
read  output  1  read strobe.
waitrequest  input  1  stall; hold the request unchanged while high.
writedata  output  32  store data.
byteenable  output  4  lane enables; 4'b1111 for word accesses.
readdata  input  32  read data, valid on the cycle after the accepted read.

Behaviour:
- Reset (asynchronous assert, synchronous release): PC=RESET_VECTOR, GPRs=0, active=0, read=write=0, address=0, byteenable=0, state=FETCH.
- First rising edge with reset deasserted: active=1.
- FSM states:
  - FETCH: read=1, address=PC. Advance when waitrequest=0.
  - DECODE: capture readdata as IR; read registers.
  - EXEC: ALU operation, branch compare, address generation.
  - MEM: loads/stores only. Hold while waitrequest=1; loads latch readdata on the following cycle.
  - WB: register write; PC update.
  - HALTED: no bus activity, active=0. Leave only via reset.
- Bus rules: read and write are never both high. Strobes and address are held stable while waitrequest=1. Otherwise each strobe is one cycle.
- ISA subset:
  - ALU register ops: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV.
  - ALU immediate ops: ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI.
  - Memory: LW, SW.
  - Control: BEQ, BNE, BGTZ, BLEZ, BLTZ, BGEZ, J, JAL, JR, JALR.
  - Unrecognised opcodes execute as NOP.
- Immediates: sign-extended, except ANDI/ORI/XORI, which are zero-extended. No overflow traps.
- $0 always reads 0; writes to it are discarded.
- Branches and jumps have one delay slot. The next sequential instruction always executes before the target.
  - Branch target = PC+4 + (sext(imm)<<2).
  - J/JAL target = {(PC+4)[31:28], instr_index, 2'b00}.
  - JAL writes PC+8 to $31. JALR writes PC+8 to rd.
- Halt: when the PC about to be fetched equals HALT_ADDR (after the delay slot completes), enter HALTED; active falls that cycle.
- Reset mid-transaction: aborts immediately; the bus returns to idle.
- register_v0 updates the cycle after the WB that writes $2.

Optional Feature:
MIPS_MULTDIV_EN:
- Defined: adds HI/LO registers and MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
  - MULT/MULTU: 64-bit signed/unsigned product, HI:LO.
  - DIV/DIVU: LO=quotient, HI=remainder.
  - Divide by zero leaves HI/LO unchanged.
- Undefined: these opcodes execute as NOP.

Decomposition:
- Package mips_cpu_pkg holds:
  - opcode/funct constants;
  - FSM state enum;
  - ALU-op enum;
  - RESET_VECTOR default.
- One sub-module, mips_cpu_alu: combinational ALU with shifter and comparisons.
- Register file and FSM stay inline in the top module.

Test Plan:
- Reset/boot: reset low 2 cycles, then high → active=1 within 1 cycle; first bus read at 0xBFC00000.
- JAL with delay slot: LUI $t0,0xBFC0; JAL 0x0FF00006; LW; JR $0; NOP; NOP; JR $0 at 0xBFC00018; ADDIU $v0,$ra,0 → active=0, register_v0=0xBFC0000C.
- LW via $t0 base: LUI $t0,0xBFC0; LW $v0,0x2C($t0) with word 0xBFC0002C = 1; JR $0; NOP → register_v0=1, then halt.
- waitrequest stall: waitrequest=1 for 5 cycles on fetch and on SW → address, read/write, writedata stable throughout; final result unchanged.
- Branch delay slot: BEQ $0,$0 taken; delay slot ADDIU $v0,$0,5; target ADDIU $v0,$v0,1; JR $0; NOP → register_v0=6.
- $0 write protection: ADDIU $0,$0,7; ADDU $v0,$0,$0; JR $0; NOP → register_v0=0.
